// File: rtl/mod_counter_if.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mod_counter_if
// Bundles the control, data and status signals of mod_counter.
//   master : drives EN, Clear, LoadMod, Load, Din, Start, OneShot, Up;
//            observes Q, Cout, Busy, Done.
//   slave  : the counter itself (mirror image of master).
// N must match the N parameter of the mod_counter instance it is bound to.
// -----------------------------------------------------------------------------
interface mod_counter_if #(
    parameter int N = 26
);
    logic         EN;
    logic         Clear;
    logic         LoadMod;
    logic         Load;
    logic [N-1:0] Din;
    logic         Start;
    logic         OneShot;
    logic         Up;
    logic [N-1:0] Q;
    logic         Cout;
    logic         Busy;
    logic         Done;

    modport master (
        output EN, Clear, LoadMod, Load, Din, Start, OneShot, Up,
        input  Q, Cout, Busy, Done
    );

    modport slave (
        input  EN, Clear, LoadMod, Load, Din, Start, OneShot, Up,
        output Q, Cout, Busy, Done
    );
endinterface

// File: rtl/mod_counter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mod_counter
// Programmable-modulus counter with preset load, free-run / one-shot modes,
// a start/done handshake and a one-cycle terminal-count pulse.
//
// Optional feature macro: MOD_COUNTER_UPDOWN_EN
//   defined   : bus.Up selects up (1) or down (0) counting.
//   undefined : always counts up; no down-count logic is built.
//
// Ports:
//   Clock    - rising-edge clock
//   Reset_n  - asynchronous active-low reset
//   bus      - mod_counter_if.slave:
//                EN       count enable (qualifies steps and terminal events)
//                Clear    synchronous clear, highest priority
//                LoadMod  load modulus M from Din (Din=0 ignored), zeroes Q
//                Load     preset Q from Din, saturated to M-1
//                Din      data for Load / LoadMod
//                Start    start / restart request
//                OneShot  mode latched on Start: 1 one-shot, 0 free-run
//                Up       direction (only with MOD_COUNTER_UPDOWN_EN)
//                Q        registered count, range 0..M-1
//                Cout     registered one-cycle terminal-count pulse
//                Busy     high in RUN
//                Done     high in DONE
// -----------------------------------------------------------------------------
module mod_counter #(
    parameter int N           = 26,
    parameter int DEFAULT_MOD = 50000000
) (
    input  logic          Clock,
    input  logic          Reset_n,
    mod_counter_if.slave  bus
);

    // State encoding chosen so Busy and Done are direct register bits.
    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] RUN  = 2'b01;
    localparam logic [1:0] DONE = 2'b10;

    localparam logic [N-1:0] L_DEFAULT_MOD = N'(DEFAULT_MOD);
    localparam logic [N-1:0] L_ONE         = N'(1);
    localparam logic [N-1:0] L_ZERO        = '0;

    logic [1:0]   r_state;
    logic         r_mode;      // 1 = one-shot, 0 = free-run
    logic [N-1:0] r_q;
    logic [N-1:0] r_m;
    logic         r_cout;

    logic [N-1:0] w_m_minus1;
    logic [N-1:0] w_load_q;
    logic [N-1:0] w_next_q;    // non-terminal step value
    logic [N-1:0] w_wrap_q;    // value after a terminal step, also the start value
    logic         w_term;

    assign w_m_minus1 = r_m - L_ONE;
    assign w_load_q   = (bus.Din >= r_m) ? w_m_minus1 : bus.Din;

`ifdef MOD_COUNTER_UPDOWN_EN
    logic w_up;
    assign w_up     = bus.Up;
    assign w_term   = w_up ? (r_q == w_m_minus1) : (r_q == L_ZERO);
    assign w_next_q = w_up ? (r_q + L_ONE) : (r_q - L_ONE);
    assign w_wrap_q = w_up ? L_ZERO : w_m_minus1;
`else
    logic w_unused_up;
    assign w_unused_up = bus.Up;
    assign w_term      = (r_q == w_m_minus1);
    assign w_next_q    = r_q + L_ONE;
    assign w_wrap_q    = L_ZERO;
`endif

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= IDLE;
            r_mode  <= 1'b0;
            r_q     <= L_ZERO;
            r_m     <= L_DEFAULT_MOD;
            r_cout  <= 1'b0;
        end else begin
            // Cout is a pulse: it is only set on the terminal-step branch.
            r_cout <= 1'b0;
            if (bus.Clear) begin
                r_state <= IDLE;
                r_mode  <= 1'b0;
                r_q     <= L_ZERO;
            end else if (bus.LoadMod) begin
                // A zero modulus would be meaningless, so the write is dropped.
                if (bus.Din != L_ZERO) begin
                    r_m <= bus.Din;
                    r_q <= L_ZERO;
                end
            end else if (bus.Load) begin
                r_q <= w_load_q;
            end else if (bus.Start) begin
                r_state <= RUN;
                r_mode  <= bus.OneShot;
                r_q     <= w_wrap_q;
            end else if ((r_state == RUN) && bus.EN) begin
                if (w_term) begin
                    r_cout <= 1'b1;
                    if (r_mode) begin
                        // One-shot: Q keeps the terminal value.
                        r_state <= DONE;
                    end else begin
                        r_q <= w_wrap_q;
                    end
                end else begin
                    r_q <= w_next_q;
                end
            end
        end
    end

    assign bus.Q    = r_q;
    assign bus.Cout = r_cout;
    assign bus.Busy = r_state[0];
    assign bus.Done = r_state[1];

endmodule

// File: tb/tb_mod_counter.sv
`timescale 1ns/1ps
module tb_mod_counter;

    localparam int N    = 4;
    localparam int DMOD = 10;
    localparam int S_IDLE = 0, S_RUN = 1, S_DONE = 2;

    logic Clock;
    logic Reset_n;

    mod_counter_if #(.N(N)) bus ();

    mod_counter #(.N(N), .DEFAULT_MOD(DMOD)) dut (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        int q;
        int cout;
        int busy;
        int done;
    } exp_t;

    exp_t exp_q[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    // Reference model: plain integer view of the counter behaviour.
    int m_q, m_m, m_st, m_mode, m_cout;

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_q = 0; m_m = DMOD; m_st = S_IDLE; m_mode = 0; m_cout = 0;
    endtask

    task automatic model_update(input bit en, clr, lm, ld, st, os, up, input int din);
        bit eff_up;
        int nxt;
        bit hit;
`ifdef MOD_COUNTER_UPDOWN_EN
        eff_up = up;
`else
        eff_up = 1'b1;
`endif
        m_cout = 0;
        if (clr) begin
            m_q = 0; m_st = S_IDLE; m_mode = 0;
        end else if (lm) begin
            if (din != 0) begin m_m = din; m_q = 0; end
        end else if (ld) begin
            m_q = (din < m_m) ? din : m_m - 1;
        end else if (st) begin
            m_st = S_RUN; m_mode = os;
            m_q = eff_up ? 0 : m_m - 1;
        end else if (m_st == S_RUN && en) begin
            if (eff_up) begin
                nxt = (m_q + 1) % m_m;
                hit = (nxt == 0);
            end else begin
                hit = (m_q == 0);
                nxt = hit ? m_m - 1 : m_q - 1;
            end
            m_cout = hit;
            if (hit && m_mode) m_st = S_DONE;
            else m_q = nxt;
        end
    endtask

    // Drive one cycle of stimulus, predict the result, return 1 after the edge.
    task automatic step(input bit en, clr, lm, ld, st, os, up, input int din);
        exp_t e;
        logic [31:0] dv;
        @(negedge Clock);
        dv = din;
        bus.EN = en; bus.Clear = clr; bus.LoadMod = lm; bus.Load = ld;
        bus.Start = st; bus.OneShot = os; bus.Up = up; bus.Din = dv[N-1:0];
        model_update(en, clr, lm, ld, st, os, up, din);
        e.q = m_q; e.cout = m_cout;
        e.busy = (m_st == S_RUN); e.done = (m_st == S_DONE);
        exp_q.push_back(e);
        @(posedge Clock);
        #1;
    endtask

    task automatic run(input bit en, input bit up);
        step(en, 0, 0, 0, 0, 0, up, 0);
    endtask

    // Monitor: pops each predicted response and compares with the DUT outputs.
    always @(posedge Clock) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_q",    int'(bus.Q),    e.q);
            chk("sb_cout", int'(bus.Cout), e.cout);
            chk("sb_busy", int'(bus.Busy), e.busy);
            chk("sb_done", int'(bus.Done), e.done);
        end
    end

    initial begin
        int couts;
        bit busy_ok;
        int dn;
`ifdef MOD_COUNTER_UPDOWN_EN
        bit updown = 1'b1;
`else
        bit updown = 1'b0;
`endif
        bus.EN = 0; bus.Clear = 0; bus.LoadMod = 0; bus.Load = 0;
        bus.Start = 0; bus.OneShot = 0; bus.Up = 1; bus.Din = '0;
        Reset_n = 1'b0;
        model_reset();
        repeat (2) @(posedge Clock);
        #1;
        chk("rst_q",    int'(bus.Q), 0);
        chk("rst_cout", int'(bus.Cout), 0);
        chk("rst_busy", int'(bus.Busy), 0);
        chk("rst_done", int'(bus.Done), 0);
        @(negedge Clock);
        Reset_n = 1'b1;

        // Free-run, 25 cycles: 0..9, 0..9, 0..4
        step(1, 0, 0, 0, 1, 0, 1, 0);
        couts = 0; busy_ok = 1;
        for (int i = 0; i < 25; i++) begin
            if (i > 0) run(1, 1);
            chk("t1_q", int'(bus.Q), i % 10);
            if (bus.Cout) begin
                couts++;
                chk("t1_cout_at_zero", int'(bus.Q), 0);
            end
            if (!bus.Busy) busy_ok = 0;
        end
        chk("t1_cout_count", couts, 2);
        chk("t1_busy", int'(busy_ok), 1);

        // One-shot with M=3
        step(0, 0, 1, 0, 0, 0, 1, 3);
        step(1, 0, 0, 0, 1, 1, 1, 0);
        chk("t2_q0", int'(bus.Q), 0);
        run(1, 1); chk("t2_q1", int'(bus.Q), 1);
        run(1, 1); chk("t2_q2", int'(bus.Q), 2);
        chk("t2_cout_early", int'(bus.Cout), 0);
        run(1, 1);
        chk("t2_q_term", int'(bus.Q), 2);
        chk("t2_cout", int'(bus.Cout), 1);
        chk("t2_busy", int'(bus.Busy), 0);
        chk("t2_done", int'(bus.Done), 1);
        for (int i = 0; i < 5; i++) begin
            run(1, 1);
            chk("t2_hold_q", int'(bus.Q), 2);
            chk("t2_hold_cout", int'(bus.Cout), 0);
        end

        // EN gating, M=10
        step(0, 0, 1, 0, 0, 0, 1, 10);
        step(1, 0, 0, 0, 1, 0, 1, 0);
        run(1, 1); chk("t3_en1", int'(bus.Q), 1);
        run(0, 1); chk("t3_en0", int'(bus.Q), 1);
        run(1, 1); chk("t3_en1b", int'(bus.Q), 2);
        run(0, 1); chk("t3_en0b", int'(bus.Q), 2);
        repeat (7) run(1, 1);
        chk("t3_q9", int'(bus.Q), 9);
        for (int i = 0; i < 3; i++) begin
            run(0, 1);
            chk("t3_hold9", int'(bus.Q), 9);
            chk("t3_hold_cout", int'(bus.Cout), 0);
        end
        run(1, 1);
        chk("t3_wrap_q", int'(bus.Q), 0);
        chk("t3_wrap_cout", int'(bus.Cout), 1);

        // Load saturation and Clear priority
        step(0, 0, 0, 1, 0, 0, 1, 12);
        chk("t4_sat", int'(bus.Q), 9);
        step(1, 1, 1, 1, 1, 0, 1, 5);
        chk("t4_clr_q", int'(bus.Q), 0);
        chk("t4_clr_busy", int'(bus.Busy), 0);
        step(0, 0, 0, 1, 0, 0, 1, 15);
        chk("t4_m_kept", int'(bus.Q), 9);

        // Direction: down from M-1 when the feature is built, else up from 0
        step(1, 0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            if (i > 0) run(1, 0);
            dn = updown ? 9 - i : i;
            chk("t5_seq", int'(bus.Q), dn);
        end
        run(1, 0);
        chk("t5_wrap_q", int'(bus.Q), updown ? 9 : 0);
        chk("t5_wrap_cout", int'(bus.Cout), 1);
        step(1, 0, 0, 0, 1, 0, 0, 0);
        repeat (4) run(1, 0);
        chk("t5_pre_switch", int'(bus.Q), updown ? 5 : 4);
        run(1, 1);
        chk("t5_switch_q", int'(bus.Q), updown ? 6 : 5);
        chk("t5_switch_cout", int'(bus.Cout), 0);

        // Asynchronous reset mid-run
        step(0, 0, 1, 0, 0, 0, 1, 13);
        step(1, 0, 0, 0, 1, 0, 1, 0);
        repeat (7) run(1, 1);
        chk("t6_pre_q", int'(bus.Q), 7);
        #2;
        Reset_n = 1'b0;
        #1;
        chk("t6_q", int'(bus.Q), 0);
        chk("t6_busy", int'(bus.Busy), 0);
        chk("t6_cout", int'(bus.Cout), 0);
        bus.EN = 0; bus.Start = 0;
        model_reset();
        @(negedge Clock);
        Reset_n = 1'b1;
        step(0, 0, 0, 1, 0, 0, 1, 15);
        chk("t6_m_default", int'(bus.Q), 9);

        // Randomized traffic against the model
        for (int i = 0; i < 500; i++) begin
            bit en, clr, lm, ld, st, os, up;
            int din;
            en  = ($urandom_range(0, 9) < 7);
            clr = ($urandom_range(0, 39) == 0);
            lm  = ($urandom_range(0, 29) == 0);
            ld  = ($urandom_range(0, 19) == 0);
            st  = ($urandom_range(0, 14) == 0);
            os  = $urandom_range(0, 1);
            up  = ($urandom_range(0, 3) != 0);
            din = $urandom_range(0, 15);
            if (lm) begin ld = 0; st = 0; end
            step(en, clr, lm, ld, st, os, up, din);
        end

        step(0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge Clock);
        #2;
        chk("sb_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
